// File: rtl/vga_timing_pkg.sv
// Shared raster constants and types for the timing generator, pixel_color and sprite logic.
package vga_timing_pkg;
    localparam int H_DISPLAY   = 640;
    localparam int H_FRONT     = 16;
    localparam int H_SYNC      = 96;
    localparam int H_BACK      = 48;
    localparam int V_DISPLAY   = 480;
    localparam int V_BOTTOM    = 10;
    localparam int V_SYNC      = 2;
    localparam int V_TOP       = 33;
    localparam int H_TOTAL     = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL     = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
    localparam int SPRITE_SIZE = 16;
    localparam int POS_W       = 10;
    localparam int FRAME_W     = 10;

    typedef logic [POS_W-1:0]   pos_t;
    typedef logic [FRAME_W-1:0] frame_t;

    function automatic logic in_window(input int p, input int start, input int len);
        return (p >= start) && (p < start + len);
    endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: the generator (master) drives position, syncs and strobes; the consumer drives enable.
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    logic   enable;
    pos_t   hpos;
    pos_t   vpos;
    logic   hsync;
    logic   vsync;
    logic   visible;
    logic   line_start;
    logic   frame_start;
    frame_t frame_count;

    modport master (
        input  enable,
        output hpos, vpos, hsync, vsync, visible, line_start, frame_start, frame_count
    );

    modport slave (
        output enable,
        input  hpos, vpos, hsync, vsync, visible, line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap counter with step-in, combinational wrap-out and a window decode
// registered from the next-state count so it lines up with pos. vis_nxt feeds the top's visible flop.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL     = 800,
    parameter int WIN_START = 656,
    parameter int WIN_LEN   = 96,
    parameter int VIS_LEN   = 640
) (
    input  logic clk,
    input  logic rst,
    input  logic step,
    output pos_t pos,
    output logic wrap,
    output logic win,
    output logic vis_nxt
);
    pos_t pos_nxt;

    always_comb begin
        wrap    = step && (pos == pos_t'(TOTAL - 1));
        pos_nxt = pos;
        if (step) begin
            pos_nxt = wrap ? '0 : pos + pos_t'(1);
        end
        vis_nxt = int'(pos_nxt) < VIS_LEN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos <= '0;
            win <= in_window(0, WIN_START, WIN_LEN);
        end else begin
            pos <= pos_nxt;
            win <= in_window(int'(pos_nxt), WIN_START, WIN_LEN);
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: h counter steps on enable, its wrap steps the v counter; strobes and
// frame_count register on the same edge as the counters, so every output is mutually aligned.
module vga_timing_gen #(
    parameter int H_DISPLAY       = vga_timing_pkg::H_DISPLAY,
    parameter int H_FRONT         = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC          = vga_timing_pkg::H_SYNC,
    parameter int H_BACK          = vga_timing_pkg::H_BACK,
    parameter int V_DISPLAY       = vga_timing_pkg::V_DISPLAY,
    parameter int V_BOTTOM        = vga_timing_pkg::V_BOTTOM,
    parameter int V_SYNC          = vga_timing_pkg::V_SYNC,
    parameter int V_TOP           = vga_timing_pkg::V_TOP,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    vga_timing_gen_if.master vga
);
    import vga_timing_pkg::*;

    localparam int HT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int VT = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

    pos_t   h_pos, v_pos;
    logic   h_wrap, v_wrap;
    logic   h_win, v_win;
    logic   h_vis_nxt, v_vis_nxt;
    logic   visible_q, line_start_q, frame_start_q;
    frame_t frame_count_q;

    vga_axis_counter #(
        .TOTAL     (HT),
        .WIN_START (H_DISPLAY + H_FRONT),
        .WIN_LEN   (H_SYNC),
        .VIS_LEN   (H_DISPLAY)
    ) u_h (
        .clk     (clk),
        .rst     (rst),
        .step    (vga.enable),
        .pos     (h_pos),
        .wrap    (h_wrap),
        .win     (h_win),
        .vis_nxt (h_vis_nxt)
    );

    // v only steps on an h wrap, so its wrap already means "entering (0,0)".
    vga_axis_counter #(
        .TOTAL     (VT),
        .WIN_START (V_DISPLAY + V_BOTTOM),
        .WIN_LEN   (V_SYNC),
        .VIS_LEN   (V_DISPLAY)
    ) u_v (
        .clk     (clk),
        .rst     (rst),
        .step    (h_wrap),
        .pos     (v_pos),
        .wrap    (v_wrap),
        .win     (v_win),
        .vis_nxt (v_vis_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            visible_q     <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            visible_q     <= h_vis_nxt && v_vis_nxt;
            line_start_q  <= h_wrap;
            frame_start_q <= v_wrap;
            if (v_wrap) begin
                frame_count_q <= frame_count_q + frame_t'(1);
            end
        end
    end

    // Polarity is a constant inversion of the registered window, still one flop deep.
    assign vga.hsync       = h_win ^ SYNC_ACTIVE_LOW;
    assign vga.vsync       = v_win ^ SYNC_ACTIVE_LOW;
    assign vga.hpos        = h_pos;
    assign vga.vpos        = v_pos;
    assign vga.visible     = visible_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
    assign vga.frame_count = frame_count_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size 640x480 instances (both sync polarities) plus a tiny 7x6 raster for frame wrap.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_full, rst_pos, rst_small;

    vga_timing_gen_if if_full();
    vga_timing_gen_if if_pos();
    vga_timing_gen_if if_small();

    vga_timing_gen u_full (.clk(clk), .rst(rst_full), .vga(if_full));

    vga_timing_gen #(.SYNC_ACTIVE_LOW(1'b0)) u_pos (.clk(clk), .rst(rst_pos), .vga(if_pos));

    vga_timing_gen #(
        .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_DISPLAY(3), .V_BOTTOM(1), .V_SYNC(1), .V_TOP(1)
    ) u_small (.clk(clk), .rst(rst_small), .vga(if_small));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hs_cnt, hs_first, hs_last, hp_cnt, hp_first, vis_err, ls_cnt, fs_cnt;
        int vis_cnt, vs_cnt, seq_err, pos_err, strb_err, dec_err, fc_err, idle_cnt;
        int mh, mv, mfc;
        logic en, e_ls, e_fs;

        rst_full = 1'b1; rst_pos = 1'b1; rst_small = 1'b1;
        if_full.enable = 1'b0; if_pos.enable = 1'b0; if_small.enable = 1'b0;
        tick();
        tick();

        check("rst_hpos",        32'(if_full.hpos), 0);
        check("rst_vpos",        32'(if_full.vpos), 0);
        check("rst_visible",     32'(if_full.visible), 1);
        check("rst_hsync",       32'(if_full.hsync), 1);
        check("rst_vsync",       32'(if_full.vsync), 1);
        check("rst_line_start",  32'(if_full.line_start), 0);
        check("rst_frame_start", 32'(if_full.frame_start), 0);
        check("rst_frame_count", 32'(if_full.frame_count), 0);
        check("rst_hsync_poshi", 32'(if_pos.hsync), 0);

        // One full line from reset.
        rst_full = 1'b0; rst_pos = 1'b0;
        if_full.enable = 1'b1; if_pos.enable = 1'b1;
        ls_cnt = 0; fs_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            tick();
            ls_cnt += int'(if_full.line_start);
            fs_cnt += int'(if_full.frame_start);
        end
        check("line1_hpos",       32'(if_full.hpos), 0);
        check("line1_vpos",       32'(if_full.vpos), 1);
        check("line1_ls_count",   32'(ls_cnt), 1);
        check("line1_fs_count",   32'(fs_cnt), 0);
        check("line1_ls_now",     32'(if_full.line_start), 1);

        // Second line: sync window and visible decode, both polarities.
        hs_cnt = 0; hs_first = -1; hs_last = -1; hp_cnt = 0; hp_first = -1; vis_err = 0; ls_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            tick();
            if (if_full.hsync == 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(if_full.hpos);
                hs_last = int'(if_full.hpos);
            end
            if (if_pos.hsync == 1'b1) begin
                hp_cnt++;
                if (hp_first < 0) hp_first = int'(if_pos.hpos);
            end
            if (if_full.visible !== (if_full.hpos < 10'd640)) vis_err++;
            if (if_full.line_start !== (if_full.hpos == 10'd0)) vis_err++;
        end
        check("line2_hsync_clks",  32'(hs_cnt), 96);
        check("line2_hsync_first", 32'(hs_first), 656);
        check("line2_hsync_last",  32'(hs_last), 751);
        check("line2_vis_ls_errs", 32'(vis_err), 0);
        check("line2_poshi_clks",  32'(hp_cnt), 96);
        check("line2_poshi_first", 32'(hp_first), 656);
        check("line2_vpos",        32'(if_full.vpos), 2);

        // Reset in the middle of an hsync pulse.
        for (int i = 0; i < 700; i++) tick();
        check("mid_hpos",       32'(if_full.hpos), 700);
        check("mid_hsync",      32'(if_full.hsync), 0);
        check("mid_hsync_poshi", 32'(if_pos.hsync), 1);
        rst_full = 1'b1;
        tick();
        check("midrst_hpos",    32'(if_full.hpos), 0);
        check("midrst_vpos",    32'(if_full.vpos), 0);
        check("midrst_hsync",   32'(if_full.hsync), 1);
        check("midrst_visible", 32'(if_full.visible), 1);
        check("midrst_ls",      32'(if_full.line_start), 0);
        rst_full = 1'b0;
        if_full.enable = 1'b0; if_pos.enable = 1'b0;

        // Tiny raster: 7 x 6 = 42 clks per frame, run 1024 frames.
        rst_small = 1'b0;
        if_small.enable = 1'b1;
        vis_cnt = 0; vs_cnt = 0; fs_cnt = 0; seq_err = 0;
        for (int k = 1; k <= 42 * 1024; k++) begin
            tick();
            if (k <= 42) begin
                vis_cnt += int'(if_small.visible);
                vs_cnt  += int'(!if_small.vsync);
                fs_cnt  += int'(if_small.frame_start);
            end
            if (if_small.frame_start !== ((k % 42) == 0)) seq_err++;
            if (32'(if_small.frame_count) !== 32'((k / 42) % 1024)) seq_err++;
            if (k == 42) check("frame1_count", 32'(if_small.frame_count), 1);
            if (k == 42 * 1023) check("frame1023_count", 32'(if_small.frame_count), 1023);
        end
        check("frame1_visible_clks", 32'(vis_cnt), 12);
        check("frame1_vsync_clks",   32'(vs_cnt), 7);
        check("frame1_fs_count",     32'(fs_cnt), 1);
        check("frames_seq_errs",     32'(seq_err), 0);
        check("wrap_frame_count",    32'(if_small.frame_count), 0);
        check("wrap_frame_start",    32'(if_small.frame_start), 1);

        // Random enable against a reference position model.
        mh = 0; mv = 0; mfc = 0;
        pos_err = 0; strb_err = 0; dec_err = 0; fc_err = 0; idle_cnt = 0;
        for (int i = 0; i < 600; i++) begin
            en = 1'($urandom_range(0, 1));
            if_small.enable = en;
            tick();
            e_ls = en && (mh == 6);
            e_fs = e_ls && (mv == 5);
            if (en) mh = (mh == 6) ? 0 : mh + 1;
            if (e_ls) mv = (mv == 5) ? 0 : mv + 1;
            if (e_fs) mfc = (mfc + 1) % 1024;
            if (!en) idle_cnt++;
            if (int'(if_small.hpos) != mh || int'(if_small.vpos) != mv) pos_err++;
            if (if_small.line_start !== e_ls || if_small.frame_start !== e_fs) strb_err++;
            if (if_small.hsync !== (mh != 5) || if_small.vsync !== (mv != 4)) dec_err++;
            if (if_small.visible !== (mh < 4 && mv < 3)) dec_err++;
            if (int'(if_small.frame_count) != mfc) fc_err++;
        end
        check("rand_pos_errs",    32'(pos_err), 0);
        check("rand_strobe_errs", 32'(strb_err), 0);
        check("rand_decode_errs", 32'(dec_err), 0);
        check("rand_fc_errs",     32'(fc_err), 0);
        check("rand_frame_count", 32'(if_small.frame_count), 32'(mfc));
        check("rand_has_idle",    32'(idle_cnt > 0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
